fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the single-cycle RV32I core, sitting directly upstream of the instruction memory. It owns the program counter, drives the word-aligned byte address into the instruction memory, captures the returned instruction with its PC into a 2-entry buffer, and hands it to decode over a valid/ready handshake. Branch/jump redirects from execute flush the buffer. Misaligned targets halt fetch and raise an error.

## Interface
- AW, 32, address width (byte address)
- DW, 32, instruction width
- RESET_PC, 32'h0000_0000, PC loaded on reset

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_addr  out  AW  byte address to instruction memory; equals current PC register
- imem_data  in  DW  instruction returned combinationally by instruction memory for imem_addr
- redirect_valid  in  1  execute requests PC change this cycle
- redirect_pc  in  AW  new PC target
- out_valid  out  1  buffer head holds a valid instruction
- out_ready  in  1  decode accepts head this cycle
- out_pc  out  AW  PC of head instruction
- out_instr  out  DW  head instruction, passed through unmodified (byte order as assembled by memory)
- misalign_err  out  1  sticky; set when a redirect target has redirect_pc[1:0] != 0

## Operation
- States: RUN, HALT. Reset enters RUN.
- Reset values: PC = RESET_PC, buffer empty, out_valid = 0, out_pc = 0, out_instr = 0, misalign_err = 0. imem_addr = RESET_PC.
- Pop: head removed when out_valid && out_ready.
- Push (RUN only): when no redirect, and buffer has room after this cycle's pop (count < 2, or count == 2 with pop), write {PC, imem_data} and PC <= PC + 4.
- PC arithmetic modulo 2^AW; PC 32'hFFFF_FFFC + 4 wraps to 0, no flag.
- Redirect (any state) has priority over push and pop: buffer flushed to empty, no push that cycle, any concurrent pop discarded.
  - redirect_pc[1:0] == 0: PC <= redirect_pc, state RUN, misalign_err <= 0.
  - otherwise: PC <= redirect_pc, state HALT, misalign_err <= 1.
- HALT: no pushes; buffer stays empty; leaves HALT only via aligned redirect.
- Buffer: 2-entry FIFO, oldest at head; order strictly preserved.
- Async reset mid-stream: all state returns to reset values immediately; in-flight entries lost.

## Timing
- imem_addr is registered PC, no combinational path from any input.
- out_* driven from buffer registers only; no combinational path from imem_data, redirect_* or out_ready to out_valid/out_pc/out_instr.
- Latency: instruction at PC visible on out_* one cycle after PC is presented on imem_addr.
- First out_valid = 1 in first cycle after rst_n release edge + 1 clk.
- Throughput: one instruction per cycle with out_ready held high.
- out_ready low: buffer fills to 2 and fetch stalls (PC held); resumes the cycle out_ready rises, no bubble.
- Redirect at edge N: out_valid = 0 in cycle N+1; instruction at redirect_pc appears at N+2.

## Structure
- Shared package rv32i_pkg: RESET_PC default, XLEN = 32, INSTR_ALIGN_MASK = 2'b11, state encoding for RUN/HALT.
- Sub-module fetch_fifo: parameterised 2-entry FIFO (width AW+DW) with push, pop, flush, count; async active-low reset.

## Test plan
- Reset release, out_ready = 1, memory returning PC-derived words -> out_pc 0,4,8,12 consecutive cycles, out_instr matches, no bubbles.
- Hold out_ready = 0 for 5 cycles from reset -> buffer holds PC 0 and 4, imem_addr stays 8; release -> 0,4,8 delivered back-to-back.
- Redirect to 32'h100 while buffer holds 2 entries and out_ready = 1 -> next cycle out_valid = 0, following cycle out_pc = 32'h100.
- Redirect to 32'h102 -> misalign_err = 1, out_valid stays 0 indefinitely; then redirect to 32'h200 -> misalign_err = 0, out_pc = 32'h200 delivered.
- PC = 32'hFFFF_FFFC running -> next out_pc = 0.
- Assert rst_n low mid-stream with full buffer -> out_valid = 0, imem_addr = RESET_PC immediately, no clock needed.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the fetch stage: data widths, the reset PC,
// the instruction alignment mask and the fetch FSM state encoding.
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Low PC bits that must be zero for a legal 32-bit instruction address
  localparam logic [1:0] INSTR_ALIGN_MASK = 2'b11;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  function automatic logic is_aligned(input logic [1:0] addr_lo);
    return (addr_lo & INSTR_ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Decode-side handshake of the fetch stage: head instruction, its PC and
// the valid/ready pair. The fetch unit is the master, decode the slave.
interface fetch_unit_if #(
  parameter int AW = rv32i_pkg::XLEN,
  parameter int DW = rv32i_pkg::XLEN
);

  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_pc;
  logic [DW-1:0] out_instr;

  modport master (
    output out_valid,
    output out_pc,
    output out_instr,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_pc,
    input  out_instr,
    output out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry FIFO holding {pc, instr} pairs between instruction memory and
// decode. Entry 0 is always the head, so the read port is a plain register.
module fetch_fifo #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [1:0]   count
);

  logic [W-1:0] entry0_q, entry0_d;
  logic [W-1:0] entry1_q, entry1_d;
  logic [1:0]   count_q, count_d;
  logic [1:0]   level;
  logic         do_pop;
  logic         do_push;

  // Next-state: pop shifts entry 1 into the head, push lands in the first
  // free slot left after that shift; flush simply empties the queue.
  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'd2) || do_pop);
    level    = count_q - {1'b0, do_pop};
    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (do_pop) begin
        entry0_d = entry1_q;
      end
      if (do_push) begin
        if (level == 2'd0) begin
          entry0_d = wdata;
        end else begin
          entry1_d = wdata;
        end
      end
      count_d = level + {1'b0, do_push};
    end
  end

  // Storage and occupancy registers, cleared on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      count_q  <= count_d;
    end
  end

  assign rdata = entry0_q;
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory,
// buffers returned instructions in a 2-entry FIFO and hands them to decode.
// Redirects flush the buffer; a misaligned target halts fetch.
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter int            AW       = XLEN,
  parameter int            DW       = XLEN,
  parameter logic [AW-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_data,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  fetch_unit_if.master  out_if,
  output logic          misalign_err
);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          misalign_q, misalign_d;
  logic          push;
  logic          pop;
  logic [1:0]    fifo_count;
  logic [AW+DW-1:0] fifo_head;

  // A redirect discards whatever decode would have taken this cycle
  assign pop = out_if.out_valid && out_if.out_ready && !redirect_valid;

  // Next PC / state: redirect wins, otherwise fetch whenever the buffer will
  // have room after this cycle's pop. PC wraps naturally at 2^AW.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    push       = 1'b0;
    if (redirect_valid) begin
      pc_d = redirect_pc;
      if (is_aligned(redirect_pc[1:0])) begin
        state_d    = RUN;
        misalign_d = 1'b0;
      end else begin
        state_d    = HALT;
        misalign_d = 1'b1;
      end
    end else if ((state_q == RUN) && ((fifo_count != 2'd2) || pop)) begin
      push = 1'b1;
      pc_d = pc_q + AW'(4);
    end
  end

  // Fetch FSM with registered PC and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  fetch_fifo #(
    .W(AW + DW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({pc_q, imem_data}),
    .rdata (fifo_head),
    .count (fifo_count)
  );

  assign imem_addr        = pc_q;
  assign misalign_err     = misalign_q;
  assign out_if.out_valid = (fifo_count != 2'd0);
  assign out_if.out_pc    = fifo_head[AW+DW-1:DW];
  assign out_if.out_instr = fifo_head[DW-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, back-pressure, redirects,
// misaligned halt, PC wrap and asynchronous reset mid-stream.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign_err;

  int checks;
  int errors;

  fetch_unit_if #(.AW(32), .DW(32)) out_if ();

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_if         (out_if.master),
    .misalign_err   (misalign_err)
  );

  // Instruction memory model: a distinct word derived from each address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_data = mem_word(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then step past the next rising edge
  task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic rdy);
    redirect_valid   = rv;
    redirect_pc      = rpc;
    out_if.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check the full head view of the decode port
  task automatic checkHead(input string tag, input logic [31:0] pc);
    checkOutput({tag, "_valid"}, {31'd0, out_if.out_valid}, 32'd1);
    checkOutput({tag, "_pc"}, out_if.out_pc, pc);
    checkOutput({tag, "_instr"}, out_if.out_instr, mem_word(pc));
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst_n            = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = 32'd0;
    out_if.out_ready = 1'b1;

    // Reset state
    #2;
    checkOutput("rst_valid", {31'd0, out_if.out_valid}, 32'd0);
    checkOutput("rst_pc", out_if.out_pc, 32'd0);
    checkOutput("rst_instr", out_if.out_instr, 32'd0);
    checkOutput("rst_err", {31'd0, misalign_err}, 32'd0);
    checkOutput("rst_addr", imem_addr, 32'd0);

    // Streaming with out_ready high: 0,4,8,12 with no bubbles
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkHead("stream0", 32'd0);
    checkOutput("stream0_addr", imem_addr, 32'd4);
    for (int k = 1; k < 4; k++) begin
      applyStimulus(1'b0, 32'd0, 1'b1);
      checkHead("stream", 32'(k * 4));
    end

    // Back-pressure from reset: buffer fills with 0 and 4, PC parks at 8
    rst_n = 1'b0;
    #2;
    checkOutput("rst2_valid", {31'd0, out_if.out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 32'd0, 1'b0);
    end
    checkHead("stall", 32'd0);
    checkOutput("stall_addr", imem_addr, 32'd8);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkHead("resume4", 32'd4);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkHead("resume8", 32'd8);

    // Redirect with a full buffer and decode ready
    applyStimulus(1'b1, 32'h100, 1'b1);
    checkOutput("redir_valid", {31'd0, out_if.out_valid}, 32'd0);
    checkOutput("redir_addr", imem_addr, 32'h100);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkHead("redir_head", 32'h100);

    // Misaligned redirect halts fetch until an aligned redirect
    applyStimulus(1'b1, 32'h102, 1'b1);
    checkOutput("mis_err", {31'd0, misalign_err}, 32'd1);
    checkOutput("mis_valid", {31'd0, out_if.out_valid}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 32'd0, 1'b1);
      checkOutput("halt_valid", {31'd0, out_if.out_valid}, 32'd0);
      checkOutput("halt_err", {31'd0, misalign_err}, 32'd1);
      checkOutput("halt_addr", imem_addr, 32'h102);
    end
    applyStimulus(1'b1, 32'h200, 1'b1);
    checkOutput("realign_err", {31'd0, misalign_err}, 32'd0);
    checkOutput("realign_valid", {31'd0, out_if.out_valid}, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkHead("realign_head", 32'h200);

    // PC wrap at the top of the address space
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkHead("wrap_top", 32'hFFFF_FFFC);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkHead("wrap_zero", 32'd0);
    checkOutput("wrap_addr", imem_addr, 32'd4);
    checkOutput("wrap_err", {31'd0, misalign_err}, 32'd0);

    // Fill the buffer, then assert reset between clock edges
    applyStimulus(1'b0, 32'd0, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkHead("full", 32'd0);
    checkOutput("full_addr", imem_addr, 32'd8);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", {31'd0, out_if.out_valid}, 32'd0);
    checkOutput("arst_addr", imem_addr, 32'd0);
    checkOutput("arst_pc", out_if.out_pc, 32'd0);
    checkOutput("arst_instr", out_if.out_instr, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkHead("post_rst", 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
